// File: rtl/dma_ps2_wr_pkg.sv
// Purpose : shared types and constants for the PS2 DMA write channel.
// Latency : n/a (definitions only).
// Backpr. : n/a.
package dma_pkg;

   // DMA channel state encoding
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WRITE   = 2'd2,
      ST_RELEASE = 2'd3
   } dma_state_e;

   localparam int          DMA_DEPTH      = 16;
   localparam int          DMA_IRQ_THRESH = 4;
   localparam logic [31:0] PS2_BASE       = 32'h0000_000A;

   // Word captured from the peripheral together with the ring base it belongs to
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] base;
   } hold_t;

   // Word address of a ring slot: base plus zero-extended slot index
   function automatic logic [31:0] ring_addr(input logic [31:0] base,
                                             input logic [31:0] slot);
      return base + slot;
   endfunction

endpackage

// File: rtl/dma_ps2_wr_if.sv
// Purpose : peripheral/CPU/memory-side signal bundle of the PS2 DMA write channel.
// Latency : n/a (wires only).
// Backpr. : bus_req/bus_grant handshake; the channel waits on the grant indefinitely.
// Ports   : slave = DMA channel (consumes listo/joi/dire/bus_grant/irq_ack),
//           master = surrounding system (drives those, observes the rest).
interface dma_ps2_wr_if #(
   parameter int PTR_W = 4
);
   logic             listo;
   logic [31:0]      joi;
   logic [31:0]      dire;
   logic             bus_grant;
   logic             irq_ack;
   logic             bus_req;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             done;
   logic             irq;
   logic             overrun;
   logic             busy;
   logic [PTR_W-1:0] wr_ptr;

   modport master (
      output listo, joi, dire, bus_grant, irq_ack,
      input  bus_req, mem_we, mem_addr, mem_wdata, done, irq, overrun, busy, wr_ptr
   );

   modport slave (
      input  listo, joi, dire, bus_grant, irq_ack,
      output bus_req, mem_we, mem_addr, mem_wdata, done, irq, overrun, busy, wr_ptr
   );
endinterface

// File: rtl/dma_ps2_wr_edge_capture.sv
// Purpose : rising-edge detect on listo, one-word holding register, sticky overrun flag.
// Latency : 1 cycle from listo rising to o_pend.
// Backpr. : a new edge while a word is pending (outside the write cycle) is dropped and flagged.
// Ports   : i_listo/i_joi/i_dire from the peripheral; i_in_write = channel is in its write
//           cycle; o_pend/o_hold feed the FSM; o_overrun is sticky until reset.
module edge_capture
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_listo,
   input  logic [31:0] i_joi,
   input  logic [31:0] i_dire,
   input  logic        i_in_write,
   output logic        o_pend,
   output hold_t       o_hold,
   output logic        o_overrun
);
   logic  r_listo_d;
   logic  r_pend;
   logic  r_overrun;
   hold_t r_hold;
   logic  w_rise;

   assign w_rise = i_listo & ~r_listo_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_listo_d <= 1'b0;
         r_pend    <= 1'b0;
         r_overrun <= 1'b0;
         r_hold    <= '0;
      end else begin
         r_listo_d <= i_listo;
         // In the write cycle the held word has already been sampled into the
         // memory registers, so a coinciding edge may overwrite it safely.
         if (w_rise && (!r_pend || i_in_write)) begin
            r_hold <= '{data: i_joi, base: i_dire};
            r_pend <= 1'b1;
         end else begin
            if (w_rise)
               r_overrun <= 1'b1;
            if (i_in_write)
               r_pend <= 1'b0;
         end
      end
   end

   assign o_pend    = r_pend;
   assign o_hold    = r_hold;
   assign o_overrun = r_overrun;
endmodule

// File: rtl/dma_ps2_wr.sv
// Purpose : DMA write channel moving PS2 words into a memory ring buffer, with threshold irq.
// Latency : listo rising to mem_we = 3 cycles when bus_grant is already high.
// Backpr. : holds bus_req until granted (unbounded); one word buffered, extra words -> overrun.
// Ports   : clk, rst (async active-low); bus = slave side of dma_ps2_wr_if
//           (listo/joi/dire in, bus_req/bus_grant, mem_we/mem_addr/mem_wdata out,
//           done/irq/overrun/busy/wr_ptr status, irq_ack in).
module dma_ps2_wr
   import dma_pkg::*;
#(
   parameter int DEPTH      = DMA_DEPTH,
   parameter int PTR_W      = 4,
   parameter int IRQ_THRESH = DMA_IRQ_THRESH
)(
   input  logic       clk,
   input  logic       rst,
   dma_ps2_wr_if.slave bus
);
   localparam int              CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);

   dma_state_e       r_state;
   dma_state_e       w_next;
   logic             r_bus_req;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_mem_wdata;
   logic             r_done;
   logic             r_irq;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_cnt;

   logic             w_pend;
   logic             w_overrun;
   logic             w_in_write;
   hold_t            w_hold;

   assign w_in_write = (r_state == ST_WRITE);

   edge_capture u_cap (
      .clk        (clk),
      .rst        (rst),
      .i_listo    (bus.listo),
      .i_joi      (bus.joi),
      .i_dire     (bus.dire),
      .i_in_write (w_in_write),
      .o_pend     (w_pend),
      .o_hold     (w_hold),
      .o_overrun  (w_overrun)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_pend)         w_next = ST_REQ;
         ST_REQ:     if (bus.bus_grant)  w_next = ST_WRITE;
         ST_WRITE:                       w_next = ST_RELEASE;
         ST_RELEASE: if (!bus.bus_grant) w_next = ST_IDLE;
         default:                        w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_bus_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_done      <= 1'b0;
         r_irq       <= 1'b0;
         r_wr_ptr    <= '0;
         r_cnt       <= '0;
      end else begin
         r_state <= w_next;
         // Request is held through the write cycle and dropped on release.
         r_bus_req <= (w_next == ST_REQ) || (w_next == ST_WRITE);
         r_done    <= w_in_write;

         // Address/data are loaded on the grant edge so they are stable for the
         // whole write cycle and keep their value afterwards.
         if (r_state == ST_REQ && bus.bus_grant) begin
            r_mem_addr  <= ring_addr(w_hold.base, {{(32-PTR_W){1'b0}}, r_wr_ptr});
            r_mem_wdata <= w_hold.data;
         end

         if (w_in_write) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;   // DEPTH is 2**PTR_W, wraps naturally
            if (bus.irq_ack) begin
               // Ack wins, but the word being written still counts.
               r_cnt <= CNT_W'(1);
               r_irq <= 1'b0;
            end else if (r_cnt != THRESH_C) begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt + 1'b1 == THRESH_C)
                  r_irq <= 1'b1;
            end
         end else if (bus.irq_ack) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
         end
      end
   end

   assign bus.bus_req   = r_bus_req;
   assign bus.mem_we    = w_in_write;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.done      = r_done;
   assign bus.irq       = r_irq;
   assign bus.overrun   = w_overrun;
   assign bus.busy      = (r_state != ST_IDLE) | w_pend;
   assign bus.wr_ptr    = r_wr_ptr;
endmodule
